// File: rtl/mrv1_retire_if.sv
// Completion, queue-head, flush and retire signals of the retirement unit.
// The slave side belongs to the retire block; the master side drives it.
interface mrv1_retire_if #(
    parameter int NUM_THREADS_P = 8,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_WB_P      = 2
);
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);

    logic [NUM_WB_P-1:0]                          wb_vld_i;
    logic [NUM_WB_P-1:0][TID_WIDTH_LP-1:0]        wb_tid_i;
    logic [NUM_WB_P-1:0][ITAG_WIDTH_P-1:0]        wb_itag_i;
    logic [NUM_THREADS_P-1:0]                     iq_retire_rdy_i;
    logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]   iq_retire_itag_i;
    logic                                         flush_vld_i;
    logic [TID_WIDTH_LP-1:0]                      flush_tid_i;
    logic                                         retire_vld_o;
    logic [TID_WIDTH_LP-1:0]                      retire_tid_o;
    logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]   retire_cnt_o;
    logic [31:0]                                  retire_total_o;

    modport slave (
        input  wb_vld_i, wb_tid_i, wb_itag_i,
        input  iq_retire_rdy_i, iq_retire_itag_i,
        input  flush_vld_i, flush_tid_i,
        output retire_vld_o, retire_tid_o, retire_cnt_o, retire_total_o
    );

    modport master (
        output wb_vld_i, wb_tid_i, wb_itag_i,
        output iq_retire_rdy_i, iq_retire_itag_i,
        output flush_vld_i, flush_tid_i,
        input  retire_vld_o, retire_tid_o, retire_cnt_o, retire_total_o
    );
endinterface

// File: rtl/mrv1_retire.sv
// In-order retirement: per-thread completion tracking, contiguous run detection
// from each queue head, and a round-robin pick of one thread per cycle.

// One thread's done row, its run length from the head and its eligibility.
module mrv1_retire_lane #(
    parameter int ITAG_WIDTH_P = 3,
    parameter int MAX_RETIRE_P = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [(1<<ITAG_WIDTH_P)-1:0]   set_i,
    input  logic                           flush_i,
    input  logic                           grant_i,
    input  logic                           rdy_i,
    input  logic [ITAG_WIDTH_P-1:0]        head_i,
    output logic [ITAG_WIDTH_P-1:0]        run_len_o,
    output logic                           elig_o
);
    localparam int IQ_SZ_LP = 1 << ITAG_WIDTH_P;

    logic [IQ_SZ_LP-1:0]     done_q;
    logic [IQ_SZ_LP-1:0]     done_d;
    logic [IQ_SZ_LP-1:0]     clr;
    logic [ITAG_WIDTH_P-1:0] idx;
    logic [ITAG_WIDTH_P-1:0] off;
    logic                    stop;

    // Run stops at the first clear bit; the cap keeps it from wrapping onto itself.
    always_comb begin
        run_len_o = '0;
        stop      = 1'b0;
        idx       = '0;
        for (int k = 0; k < MAX_RETIRE_P; k++) begin
            idx = head_i + ITAG_WIDTH_P'(k);
            if (!stop && done_q[idx])
                run_len_o = run_len_o + ITAG_WIDTH_P'(1);
            else
                stop = 1'b1;
        end
    end

    assign elig_o = rdy_i && (run_len_o != '0) && !flush_i;

    always_comb begin
        clr = '0;
        off = '0;
        for (int e = 0; e < IQ_SZ_LP; e++) begin
            off    = ITAG_WIDTH_P'(e) - head_i;
            clr[e] = grant_i && (off < run_len_o);
        end
    end

    // A completion landing on a just-retired tag belongs to the tag's new occupant.
    assign done_d = flush_i ? '0 : ((done_q & ~clr) | set_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) done_q <= '0;
        else       done_q <= done_d;
    end
endmodule

module mrv1_retire #(
    parameter int NUM_THREADS_P = 8,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_WB_P      = 2,
    parameter int MAX_RETIRE_P  = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    mrv1_retire_if.slave  bus
);
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P);
    localparam int IQ_SZ_LP     = 1 << ITAG_WIDTH_P;

    logic [NUM_THREADS_P-1:0][IQ_SZ_LP-1:0]      set_mat;
    logic [NUM_THREADS_P-1:0]                    flush_t;
    logic [NUM_THREADS_P-1:0]                    grant_t;
    logic [NUM_THREADS_P-1:0]                    elig;
    logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]  run_len;
    logic [TID_WIDTH_LP-1:0]                     rr_q;
    logic [TID_WIDTH_LP-1:0]                     gnt_tid;
    logic [TID_WIDTH_LP-1:0]                     cand;
    logic                                        gnt_vld;
    logic [31:0]                                 total_q;

    // Duplicate hits from several ports simply OR into the same bit.
    always_comb begin
        set_mat = '0;
        for (int p = 0; p < NUM_WB_P; p++)
            if (bus.wb_vld_i[p])
                set_mat[bus.wb_tid_i[p]][bus.wb_itag_i[p]] = 1'b1;
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_tid = rr_q;
        cand    = '0;
        for (int i = 1; i <= NUM_THREADS_P; i++) begin
            cand = TID_WIDTH_LP'((int'(rr_q) + i) % NUM_THREADS_P);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_tid = cand;
            end
        end
        if (rst_i) gnt_vld = 1'b0;
    end

    genvar t;
    generate
        for (t = 0; t < NUM_THREADS_P; t++) begin : g_lane
            assign flush_t[t] = bus.flush_vld_i && (bus.flush_tid_i == TID_WIDTH_LP'(t));
            assign grant_t[t] = gnt_vld && (gnt_tid == TID_WIDTH_LP'(t));
            assign bus.retire_cnt_o[t] = grant_t[t] ? run_len[t] : '0;

            mrv1_retire_lane #(
                .ITAG_WIDTH_P (ITAG_WIDTH_P),
                .MAX_RETIRE_P (MAX_RETIRE_P)
            ) u_lane (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .set_i     (set_mat[t]),
                .flush_i   (flush_t[t]),
                .grant_i   (grant_t[t]),
                .rdy_i     (bus.iq_retire_rdy_i[t]),
                .head_i    (bus.iq_retire_itag_i[t]),
                .run_len_o (run_len[t]),
                .elig_o    (elig[t])
            );
        end
    endgenerate

    // Pointer parks on the last thread so thread 0 is searched first after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q    <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
            total_q <= '0;
        end else if (gnt_vld) begin
            rr_q    <= gnt_tid;
            total_q <= total_q + 32'(run_len[gnt_tid]);
        end
    end

    assign bus.retire_vld_o   = gnt_vld;
    assign bus.retire_tid_o   = gnt_vld ? gnt_tid : rr_q;
    assign bus.retire_total_o = total_q;
endmodule

// File: tb/tb_mrv1_retire.sv
// Directed and random checks of mrv1_retire against a table-based retirement model.
module tb_mrv1_retire;
    localparam int NT   = 8;
    localparam int IW   = 3;
    localparam int NWB  = 2;
    localparam int MAXR = 2;
    localparam int IQ   = 1 << IW;
    localparam int TW   = $clog2(NT);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mrv1_retire_if #(.NUM_THREADS_P(NT), .ITAG_WIDTH_P(IW), .NUM_WB_P(NWB)) bus ();

    mrv1_retire #(
        .NUM_THREADS_P (NT),
        .ITAG_WIDTH_P  (IW),
        .NUM_WB_P      (NWB),
        .MAX_RETIRE_P  (MAXR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    bit          mdone [NT][IQ];
    int          mhead [NT];
    int          mrr;
    logic [31:0] mtot;
    int          last_g;
    int          last_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input int t);
        int n = 0;
        for (int k = 0; k < MAXR; k++) begin
            if (mdone[t][(mhead[t] + k) % IQ]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic bit elig(input int t);
        return bus.iq_retire_rdy_i[t] && run_len(t) > 0 &&
               !(bus.flush_vld_i && int'(bus.flush_tid_i) == t);
    endfunction

    task automatic clr_in();
        bus.wb_vld_i        = '0;
        bus.wb_tid_i        = '0;
        bus.wb_itag_i       = '0;
        bus.iq_retire_rdy_i = '0;
        bus.flush_vld_i     = 1'b0;
        bus.flush_tid_i     = '0;
    endtask

    task automatic set_wb(input int p, input int t, input int itag);
        bus.wb_vld_i[p]  = 1'b1;
        bus.wb_tid_i[p]  = TW'(t);
        bus.wb_itag_i[p] = IW'(itag);
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            mhead[t] = 0;
            for (int e = 0; e < IQ; e++) mdone[t][e] = 1'b0;
        end
        mrr  = NT - 1;
        mtot = '0;
    endtask

    // Apply reset for one cycle with completions pending so they get discarded.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_vld", 64'(bus.retire_vld_o), 64'd0);
        chk("rst_cnt", 64'(bus.retire_cnt_o), 64'd0);
        chk("rst_total", 64'(bus.retire_total_o), 64'd0);
        chk("rst_tid", 64'(bus.retire_tid_o), 64'(NT - 1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clr_in();
    endtask

    // One clock: check the combinational decision, advance the model, check the total.
    task automatic cyc();
        int g;
        logic [NT-1:0][IW-1:0] ecnt;
        logic [TW-1:0]         etid;
        for (int t = 0; t < NT; t++) bus.iq_retire_itag_i[t] = IW'(mhead[t]);
        #1;
        g = -1;
        for (int i = 1; i <= NT; i++) begin
            int t = (mrr + i) % NT;
            if (g < 0 && elig(t)) g = t;
        end
        ecnt = '0;
        if (g >= 0) ecnt[g] = IW'(run_len(g));
        etid = (g >= 0) ? TW'(g) : TW'(mrr);
        chk("vld", 64'(bus.retire_vld_o), 64'(g >= 0));
        chk("tid", 64'(bus.retire_tid_o), 64'(etid));
        chk("cnt", 64'(bus.retire_cnt_o), 64'(ecnt));
        last_g = g;
        last_n = (g >= 0) ? run_len(g) : 0;
        @(posedge clk);
        if (g >= 0) begin
            for (int k = 0; k < last_n; k++) mdone[g][(mhead[g] + k) % IQ] = 1'b0;
            mhead[g] = (mhead[g] + last_n) % IQ;
            mrr      = g;
            mtot     = mtot + 32'(last_n);
        end
        for (int p = 0; p < NWB; p++)
            if (bus.wb_vld_i[p]) mdone[bus.wb_tid_i[p]][bus.wb_itag_i[p]] = 1'b1;
        if (bus.flush_vld_i)
            for (int e = 0; e < IQ; e++) mdone[bus.flush_tid_i][e] = 1'b0;
        @(negedge clk);
        chk("total", 64'(bus.retire_total_o), 64'(mtot));
    endtask

    initial begin
        clr_in();
        bus.iq_retire_itag_i = '0;
        model_reset();
        @(negedge clk);
        set_wb(0, 1, 1);
        do_reset();

        // Two completions on both ports, retired together the following cycle.
        set_wb(0, 2, 0); set_wb(1, 2, 1);
        bus.iq_retire_rdy_i[2] = 1'b1;
        cyc();
        chk("wb_latency_vld", 64'(last_g), 64'(-1));
        bus.wb_vld_i = '0;
        cyc();
        chk("two_port_tid", 64'(last_g), 64'd2);
        chk("two_port_cnt", 64'(last_n), 64'd2);
        chk("two_port_total", 64'(bus.retire_total_o), 64'd2);

        // Cap at MAX_RETIRE across a run of four.
        do_reset();
        set_wb(0, 0, 0); set_wb(1, 0, 1); cyc();
        set_wb(0, 0, 2); set_wb(1, 0, 3); cyc();
        clr_in();
        bus.iq_retire_rdy_i[0] = 1'b1;
        cyc(); chk("cap_cnt1", 64'(last_n), 64'd2);
        cyc(); chk("cap_cnt2", 64'(last_n), 64'd2);
        chk("cap_total", 64'(bus.retire_total_o), 64'd4);

        // Run wrapping from the last tag back to tag 0.
        do_reset();
        mhead[1] = 7;
        set_wb(0, 1, 7); set_wb(1, 1, 0); cyc();
        clr_in();
        bus.iq_retire_rdy_i[1] = 1'b1;
        cyc(); chk("wrap_cnt", 64'(last_n), 64'd2);
        chk("wrap_clear", 64'({mdone[1][7], mdone[1][0]}), 64'd0);
        cyc(); chk("wrap_after", 64'(last_g), 64'(-1));

        // Round robin among three always-eligible threads.
        do_reset();
        for (int e = 0; e < 6; e += 2) begin
            set_wb(0, 0, e); set_wb(1, 0, e + 1); cyc();
            set_wb(0, 3, e); set_wb(1, 3, e + 1); cyc();
            set_wb(0, 5, e); set_wb(1, 5, e + 1); cyc();
        end
        clr_in();
        bus.iq_retire_rdy_i = NT'(8'b0010_1001);
        cyc(); chk("rr0", 64'(last_g), 64'd0);
        cyc(); chk("rr1", 64'(last_g), 64'd3);
        cyc(); chk("rr2", 64'(last_g), 64'd5);
        cyc(); chk("rr3", 64'(last_g), 64'd0);

        // Flush of thread 4 drops its same-cycle completion; thread 6 still retires.
        do_reset();
        set_wb(0, 4, 0); set_wb(1, 4, 1); cyc();
        set_wb(0, 6, 0); bus.wb_vld_i[1] = 1'b0; cyc();
        clr_in();
        bus.iq_retire_rdy_i[4] = 1'b1; bus.iq_retire_rdy_i[6] = 1'b1;
        bus.flush_vld_i = 1'b1; bus.flush_tid_i = TW'(4);
        set_wb(0, 4, 2);
        cyc(); chk("flush_other", 64'(last_g), 64'd6);
        bus.flush_vld_i = 1'b0; bus.wb_vld_i = '0;
        cyc(); chk("flush_none", 64'(last_g), 64'(-1));

        // Hole at the head blocks retirement until it fills.
        do_reset();
        set_wb(0, 0, 1); cyc();
        clr_in();
        bus.iq_retire_rdy_i[0] = 1'b1;
        cyc(); chk("hole_wait", 64'(last_g), 64'(-1));
        set_wb(0, 0, 0);
        cyc(); chk("hole_no_bypass", 64'(last_g), 64'(-1));
        bus.wb_vld_i = '0;
        cyc(); chk("hole_fill", 64'(last_n), 64'd2);

        // Random traffic with an occasional mid-run reset.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            for (int p = 0; p < NWB; p++)
                if ($urandom_range(0, 2) != 0) set_wb(p, $urandom_range(0, NT - 1), $urandom_range(0, IQ - 1));
                else bus.wb_vld_i[p] = 1'b0;
            bus.iq_retire_rdy_i = NT'($urandom);
            bus.flush_vld_i     = ($urandom_range(0, 15) == 0);
            bus.flush_tid_i     = TW'($urandom_range(0, NT - 1));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mrv1_retire.md
MRV1_RETIRE -- requirements
Module: mrv1_retire

Interface
REQ-001 SHALL have parameter NUM_THREADS_P, default 8, number of hardware threads.
REQ-002 SHALL have parameter ITAG_WIDTH_P, default 3, instruction tag width; IQ_SZ_LP = 2^ITAG_WIDTH_P entries per thread.
REQ-003 SHALL have parameter NUM_WB_P, default 2, number of completion (writeback) ports.
REQ-004 SHALL have parameter MAX_RETIRE_P, default 2, max instructions retired per cycle; legal range 1..IQ_SZ_LP-1.
REQ-005 SHALL have derived parameter TID_WIDTH_LP = $clog2(NUM_THREADS_P).
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 wb_vld_i  input  NUM_WB_P  per-port completion valid.
REQ-009 wb_tid_i  input  NUM_WB_P x TID_WIDTH_LP  completing thread.
REQ-010 wb_itag_i  input  NUM_WB_P x ITAG_WIDTH_P  completing instruction tag.
REQ-011 iq_retire_rdy_i  input  NUM_THREADS_P  thread's instruction queue holds an unretired entry.
REQ-012 iq_retire_itag_i  input  NUM_THREADS_P x ITAG_WIDTH_P  oldest unretired itag per thread.
REQ-013 flush_vld_i  input  1  branch flush request.
REQ-014 flush_tid_i  input  TID_WIDTH_LP  thread being flushed.
REQ-015 retire_vld_o  output  1  a retirement occurs this cycle.
REQ-016 retire_tid_o  output  TID_WIDTH_LP  retiring thread.
REQ-017 retire_cnt_o  output  NUM_THREADS_P x ITAG_WIDTH_P  per-thread count retired this cycle; zero for unselected threads.
REQ-018 retire_total_o  output  32  running count of retired instructions, wraps modulo 2^32.

Function
REQ-019 SHALL hold a done table of NUM_THREADS_P x IQ_SZ_LP flops; wb_vld_i[p] sets done[wb_tid_i[p]][wb_itag_i[p]] at the next edge.
REQ-020 Multiple ports hitting the same entry in one cycle SHALL set it once; setting an already-set bit is a no-op.
REQ-021 Per thread, run length SHALL be the count of consecutive set done bits starting at iq_retire_itag_i[t], index wrapping modulo IQ_SZ_LP, capped at MAX_RETIRE_P.
REQ-022 Thread t SHALL be eligible when iq_retire_rdy_i[t]=1, run length >=1, and not (flush_vld_i and flush_tid_i==t).
REQ-023 Round-robin arbiter SHALL grant one eligible thread per cycle, searching upward from (last granted tid + 1) modulo NUM_THREADS_P; pointer updates only in a cycle with retire_vld_o=1.
REQ-024 retire_vld_o, retire_tid_o, retire_cnt_o SHALL be combinational from registered state and current inputs (zero-cycle decision); no bypass from same-cycle wb_* into the decision.
REQ-025 Completion at edge N SHALL make the instruction retirable no earlier than the cycle following edge N (1-cycle wb-to-retire latency).
REQ-026 On a grant, the done bits of the retired entries SHALL clear at the same edge; retire_total_o SHALL add retire_cnt_o[granted] at that edge.
REQ-027 With no eligible thread: retire_vld_o=0, retire_tid_o holds last granted value, all retire_cnt_o=0.
REQ-028 flush_vld_i SHALL clear every done bit of flush_tid_i at the next edge; same-cycle wb for that thread SHALL be dropped; other threads unaffected.
REQ-029 Clear by retire and set by wb of the same entry in one cycle SHALL resolve as set (new occupant of reused tag).
REQ-030 Run length SHALL stop at the first clear bit; full wrap of all IQ_SZ_LP bits is impossible since MAX_RETIRE_P < IQ_SZ_LP.

Reset
REQ-031 rst_i SHALL asynchronously clear all done bits, RR pointer to thread NUM_THREADS_P-1 (so thread 0 is searched first), retire_total_o to 0.
REQ-032 During reset retire_vld_o=0 and all retire_cnt_o=0; reset mid-operation discards all pending completions.

Verification
REQ-033 Reset, then wb t2 itag 0 and 1 same cycle on ports 0/1, iq head t2=0, rdy=1 -> next cycle retire_vld_o=1, tid=2, cnt[2]=2; following cycle retire_total_o=2.
REQ-034 Done t0 itags {0,1,2,3}, head 0 -> cycle 1 cnt[0]=2 (cap); after head advances to 2, cycle 2 cnt[0]=2; total=4.
REQ-035 Head 7, done itags {7,0} for t1 -> cnt[1]=2 (wrap); done bits 7 and 0 cleared afterwards.
REQ-036 t0, t3, t5 all eligible continuously -> grants 0,3,5,0 on successive cycles.
REQ-037 t4 done {0,1}, flush_vld_i=1 tid 4 with wb t4 itag 2 same cycle -> no retire for t4 that cycle; all t4 done bits 0 afterwards; t6 retirement in same cycle unaffected.
REQ-038 Head 0, done only {1} -> retire_vld_o=0 until itag 0 completes, then cnt=2.
